// File: rtl/i2s_rx.sv
// I2S receiver: oversamples bclk/lrclk/din in the clk domain and deserialises
// one signed left/right pair per frame, presented with a one-cycle valid strobe.
module i2s_rx #(
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned CNTW    = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      bclk,
  input  logic                      lrclk,
  input  logic                      din,
  output logic signed [BITSIZE-1:0] left_out,
  output logic signed [BITSIZE-1:0] right_out,
  output logic                      sample_valid,
  output logic                      frame_err
);

  localparam logic [CNTW-1:0] LP_CMAX  = '1;
  localparam logic [CNTW-1:0] LP_BITS  = CNTW'(BITSIZE);
  localparam logic [CNTW-1:0] LP_SHORT = CNTW'(BITSIZE - 1);

  typedef enum logic [1:0] {ST_SYNC, ST_LEFT, ST_RIGHT} state_t;

  state_t             r_state, w_state_nx;
  logic               r_bclk_s1, r_bclk_s2, r_bclk_s3;
  logic               r_lr_s1, r_lr_s2, r_lr_d;
  logic               r_din_s1, r_din_s2;
  logic [CNTW-1:0]    r_count, w_count_nx;
  logic [BITSIZE-1:0] r_left_sr, r_right_sr, r_left_hold;
  logic [BITSIZE-1:0] w_left_sr_nx, w_right_sr_nx, w_left_hold_nx;
  logic [BITSIZE-1:0] w_left_out_nx, w_right_out_nx;
  logic               w_valid_nx, w_err_nx;
  logic               w_rise, w_change, w_room;
  logic [BITSIZE-1:0] w_left_shift, w_right_shift;
  logic [CNTW-1:0]    w_count_inc;

  assign w_rise        = r_bclk_s2 & ~r_bclk_s3;
  assign w_change      = w_rise & (r_lr_s2 != r_lr_d);
  assign w_room        = (r_count < LP_BITS);
  assign w_left_shift  = {r_left_sr[BITSIZE-2:0], r_din_s2};
  assign w_right_shift = {r_right_sr[BITSIZE-2:0], r_din_s2};
  assign w_count_inc   = (r_count == LP_CMAX) ? r_count : r_count + CNTW'(1);

  // Synchronisers and bit-edge history
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bclk_s1 <= 1'b0;
      r_bclk_s2 <= 1'b0;
      r_bclk_s3 <= 1'b0;
      r_lr_s1   <= 1'b0;
      r_lr_s2   <= 1'b0;
      r_lr_d    <= 1'b0;
      r_din_s1  <= 1'b0;
      r_din_s2  <= 1'b0;
    end else begin
      r_bclk_s1 <= bclk;
      r_bclk_s2 <= r_bclk_s1;
      r_bclk_s3 <= r_bclk_s2;
      r_lr_s1   <= lrclk;
      r_lr_s2   <= r_lr_s1;
      r_din_s1  <= din;
      r_din_s2  <= r_din_s1;
      if (w_rise) r_lr_d <= r_lr_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_SYNC;
    else     r_state <= w_state_nx;
  end

  // Next-state and datapath; the change rise still carries the old word's LSB
  always_comb begin
    w_state_nx     = r_state;
    w_count_nx     = r_count;
    w_left_sr_nx   = r_left_sr;
    w_right_sr_nx  = r_right_sr;
    w_left_hold_nx = r_left_hold;
    w_left_out_nx  = left_out;
    w_right_out_nx = right_out;
    w_valid_nx     = 1'b0;
    w_err_nx       = 1'b0;
    if (w_rise) begin
      unique case (r_state)
        ST_SYNC: begin
          if (w_change && !r_lr_s2) begin
            w_state_nx   = ST_LEFT;
            w_count_nx   = '0;
            w_left_sr_nx = '0;
          end
        end
        ST_LEFT: begin
          if (w_change) begin
            if (r_count < LP_SHORT) begin
              w_err_nx   = 1'b1;
              w_state_nx = ST_SYNC;
            end else begin
              w_left_hold_nx = w_room ? w_left_shift : r_left_sr;
              w_state_nx     = ST_RIGHT;
              w_count_nx     = '0;
              w_right_sr_nx  = '0;
            end
          end else begin
            if (w_room) w_left_sr_nx = w_left_shift;
            w_count_nx = w_count_inc;
          end
        end
        ST_RIGHT: begin
          if (w_change) begin
            if (r_count < LP_SHORT) begin
              w_err_nx = 1'b1;
            end else begin
              w_left_out_nx  = r_left_hold;
              w_right_out_nx = w_room ? w_right_shift : r_right_sr;
              w_valid_nx     = 1'b1;
            end
            w_state_nx   = ST_LEFT;
            w_count_nx   = '0;
            w_left_sr_nx = '0;
          end else begin
            if (w_room) w_right_sr_nx = w_right_shift;
            w_count_nx = w_count_inc;
          end
        end
        default: w_state_nx = ST_SYNC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count      <= '0;
      r_left_sr    <= '0;
      r_right_sr   <= '0;
      r_left_hold  <= '0;
      left_out     <= '0;
      right_out    <= '0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      r_count      <= w_count_nx;
      r_left_sr    <= w_left_sr_nx;
      r_right_sr   <= w_right_sr_nx;
      r_left_hold  <= w_left_hold_nx;
      left_out     <= w_left_out_nx;
      right_out    <= w_right_out_nx;
      sample_valid <= w_valid_nx;
      frame_err    <= w_err_nx;
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: I2S frames driven with the one-bit delay, clk = 8x bclk;
// a negedge monitor checks every valid pair, its spacing, and the error pulses.
module tb_i2s_rx;

  localparam int unsigned BITSIZE = 16;

  logic clk = 1'b0;
  logic rst, bclk, lrclk, din;
  logic signed [BITSIZE-1:0] left_out, right_out;
  logic sample_valid, frame_err;

  int n_chk = 0, n_err = 0;
  int n_valid = 0, n_ferr = 0, cyc = 0, last_cyc = 0, last_epoch = -1;
  int epoch = 0, v_at_rst = 0, n_exp = 0;
  logic signed [BITSIZE-1:0] exp_l [16];
  logic signed [BITSIZE-1:0] exp_r [16];
  logic prev_lsb = 1'b0;

  always #5 clk = ~clk;

  i2s_rx dut (
    .clk(clk), .rst(rst), .bclk(bclk), .lrclk(lrclk), .din(din),
    .left_out(left_out), .right_out(right_out),
    .sample_valid(sample_valid), .frame_err(frame_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (sample_valid || frame_err) check("excl", 32'(sample_valid & frame_err), 32'd0);
    if (frame_err) n_ferr++;
    if (sample_valid) begin
      if (n_valid < n_exp) begin
        check("left", 32'(left_out), 32'(exp_l[n_valid]));
        check("right", 32'(right_out), 32'(exp_r[n_valid]));
      end else begin
        check("unexpected_valid", 32'(n_valid), 32'(n_exp - 1));
      end
      if (last_epoch == epoch) check("period", 32'(cyc - last_cyc), 32'd512);
      last_epoch = epoch;
      last_cyc   = cyc;
      n_valid++;
    end
  end

  task automatic expect_pair(input logic [15:0] l, input logic [15:0] r);
    exp_l[n_exp] = l;
    exp_r[n_exp] = r;
    n_exp++;
  endtask

  // One channel slot of n bclk periods; period 0 carries the previous word's LSB
  task automatic send_slot(input logic ch, input logic [31:0] w, input int n, input int rst_at);
    for (int p = 0; p < n; p++) begin
      if (p == rst_at) begin
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        epoch++;
        v_at_rst = n_valid;
      end
      lrclk = ch;
      din   = (p == 0) ? prev_lsb : w[n-p];
      #40 bclk = 1'b1;
      #40 bclk = 1'b0;
    end
    prev_lsb = w[0];
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int n);
    send_slot(1'b0, l, n, -1);
    send_slot(1'b1, r, n, -1);
  endtask

  initial begin
    rst = 1'b1; bclk = 1'b0; lrclk = 1'b1; din = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_left", 32'(left_out), 32'd0);
    check("rst_right", 32'(right_out), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    send_slot(1'b1, 32'd0, 8, -1);

    // Short 8-bit slots: error on every left close, never a valid pair
    repeat (3) send_frame(32'h0000_00A5, 32'h0000_005A, 8);
    check("short_err_cnt", 32'(n_ferr), 32'd3);
    check("short_valid_cnt", 32'(n_valid), 32'd0);
    check("short_left", 32'(left_out), 32'd0);
    check("short_right", 32'(right_out), 32'd0);

    expect_pair(16'h1234, 16'hABCD);
    send_frame(32'h1234_0000, 32'hABCD_0000, 32);
    expect_pair(16'h8000, 16'h7FFF);
    send_frame(32'h8000_0000, 32'h7FFF_0000, 32);
    expect_pair(16'h1234, 16'hFEDC);
    send_frame(32'h1234_5600, 32'hFEDC_BA00, 32);
    check("left_neg", 32'(int'(left_out)), 32'(-32768));
    check("right_pos", 32'(int'(right_out)), 32'd32767);

    // Reset in the middle of a right word; this pair is lost
    send_slot(1'b0, 32'hDEAD_0000, 32, -1);
    send_slot(1'b1, 32'hBEEF_0000, 32, 12);
    check("midrst_valid", 32'(sample_valid), 32'd0);

    expect_pair(16'h0001, 16'hFFFF);
    send_frame(32'h0001_0000, 32'hFFFF_0000, 32);
    expect_pair(16'h7FFF, 16'h8000);
    send_frame(32'h7FFF_0000, 32'h8000_0000, 32);
    expect_pair(16'h5A5A, 16'hA5A5);
    send_frame(32'h5A5A_0000, 32'hA5A5_0000, 32);
    send_slot(1'b0, 32'd0, 4, -1);
    repeat (8) @(negedge clk);

    check("total_valid", 32'(n_valid), 32'd6);
    check("post_rst_valid", 32'(n_valid - v_at_rst), 32'd3);
    check("total_err", 32'(n_ferr), 32'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
